// File: rtl/vw_chunk_buffer_pkg.sv
// Shared sizing helpers for the ping-pong chunk buffer between matmul layers.
package vw_chunk_buffer_pkg;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NumBanks = 2;

endpackage

// File: rtl/vw_chunk_bank.sv
// One vector bank: scalar write port, WorkingRegs-wide combinational chunk read mux.
module vw_chunk_bank
    import vw_chunk_buffer_pkg::*;
#(
    parameter int unsigned VecLength   = 8,
    parameter int unsigned WorkingRegs = 2,
    parameter int unsigned NBits       = 8,
    localparam int unsigned ElemW      = idx_w(VecLength),
    localparam int unsigned ChunkW     = idx_w(VecLength / WorkingRegs)
) (
    input  logic                                   clk_in,
    input  logic                                   wr_en,
    input  logic [ElemW-1:0]                       wr_idx,
    input  logic [NBits-1:0]                       wr_data,
    input  logic [ChunkW-1:0]                      rd_ptr,
    output logic [WorkingRegs-1:0][NBits-1:0]      chunk_data
);

    logic [VecLength-1:0][NBits-1:0] mem_q;
    logic [VecLength-1:0][NBits-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Storage is deliberately not reset; validity is tracked by the owner's full flags.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    always_comb begin
        chunk_data = '0;
        for (int j = 0; j < int'(WorkingRegs); j++) begin
            chunk_data[j] = mem_q[ElemW'(rd_ptr) * ElemW'(WorkingRegs) + ElemW'(j)];
        end
    end

endmodule

// File: rtl/vw_chunk_buffer.sv
// Ping-pong vector buffer: upstream writes scalars into one bank while downstream reads chunks from the other.
module vw_chunk_buffer
    import vw_chunk_buffer_pkg::*;
#(
    parameter int unsigned VecLength   = 8,
    parameter int unsigned WorkingRegs = 2,
    parameter int unsigned NBits       = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              wr_en,
    input  logic [NBits-1:0]                  wr_data,
    output logic                              wr_full,
    output logic                              overflow,
    input  logic                              rd_chunk,
    input  logic                              rd_ptr_rst,
    input  logic                              rd_release,
    output logic                              data_ready,
    output logic [WorkingRegs-1:0][NBits-1:0] chunk_data
);

    localparam int unsigned NumChunks = VecLength / WorkingRegs;
    localparam int unsigned ElemW     = idx_w(VecLength);
    localparam int unsigned ChunkW    = idx_w(NumChunks);

    if ((WorkingRegs == 0) || (VecLength == 0) || ((VecLength % WorkingRegs) != 0)) begin : g_bad_cfg
        $error("vw_chunk_buffer: VecLength (%0d) must be a nonzero multiple of WorkingRegs (%0d)",
               VecLength, WorkingRegs);
    end

    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [ElemW-1:0]    wr_idx_q,  wr_idx_d;
    logic [ChunkW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [NumBanks-1:0] bank_full_q, bank_full_d;
    logic                overflow_q, overflow_d;

    logic                wr_accept;
    logic [NumBanks-1:0] bank_we;
    logic [WorkingRegs-1:0][NBits-1:0] bank_chunk [NumBanks];

    assign wr_accept = wr_en & ~bank_full_q[wr_bank_q];

    // Write side fills wr_bank; read side walks/releases rd_bank. Full flags are per bank, so
    // a completion and a release in the same cycle always touch different bits.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_ptr_d    = rd_ptr_q;
        bank_full_d = bank_full_q;
        overflow_d  = overflow_q;

        if (wr_en && bank_full_q[wr_bank_q]) begin
            overflow_d = 1'b1;
        end

        if (wr_accept) begin
            if (wr_idx_q == ElemW'(VecLength - 1)) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_idx_d               = '0;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + ElemW'(1);
            end
        end

        if (bank_full_q[rd_bank_q]) begin
            if (rd_release) begin
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = ~rd_bank_q;
                rd_ptr_d               = '0;
            end else if (rd_ptr_rst) begin
                rd_ptr_d = '0;
            end else if (rd_chunk) begin
                rd_ptr_d = (rd_ptr_q == ChunkW'(NumChunks - 1)) ? '0 : rd_ptr_q + ChunkW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_ptr_q    <= '0;
            bank_full_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_full_q <= bank_full_d;
            overflow_q  <= overflow_d;
        end
    end

    for (genvar b = 0; b < int'(NumBanks); b++) begin : g_bank
        assign bank_we[b] = wr_accept && (wr_bank_q == 1'(b));

        vw_chunk_bank #(
            .VecLength   (VecLength),
            .WorkingRegs (WorkingRegs),
            .NBits       (NBits)
        ) u_bank (
            .clk_in     (clk_in),
            .wr_en      (bank_we[b]),
            .wr_idx     (wr_idx_q),
            .wr_data    (wr_data),
            .rd_ptr     (rd_ptr_q),
            .chunk_data (bank_chunk[b])
        );
    end

    assign wr_full    = bank_full_q[wr_bank_q];
    assign overflow   = overflow_q;
    assign data_ready = bank_full_q[rd_bank_q];
    assign chunk_data = data_ready ? bank_chunk[rd_bank_q] : '0;

endmodule

// File: tb/tb_vw_chunk_buffer.sv
// Bench for vw_chunk_buffer: directed plan steps plus random traffic against a vector-queue model.
module tb_vw_chunk_buffer;

    localparam int L  = 4;
    localparam int W  = 2;
    localparam int NB = 8;
    localparam int NC = L / W;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic                      wr_en, rd_chunk, rd_ptr_rst, rd_release;
    logic [NB-1:0]             wr_data;
    logic                      wr_full, overflow, data_ready;
    logic [W-1:0][NB-1:0]      chunk_data;

    vw_chunk_buffer #(.VecLength(L), .WorkingRegs(W), .NBits(NB)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .overflow   (overflow),
        .rd_chunk   (rd_chunk),
        .rd_ptr_rst (rd_ptr_rst),
        .rd_release (rd_release),
        .data_ready (data_ready),
        .chunk_data (chunk_data)
    );

    always #5 clk_in = ~clk_in;

    int passed = 0;
    int total  = 0;

    // Model: queue of complete vectors (front = being read), a partial vector, read chunk index.
    logic [L*NB-1:0] vq[$];
    logic [L*NB-1:0] part;
    int              part_n;
    int              ptr;
    bit              ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*NB-1:0] exp_chunk();
        logic [W*NB-1:0] c = '0;
        if (vq.size() > 0) begin
            logic [L*NB-1:0] v = vq[0];
            for (int j = 0; j < W; j++) c[j*NB +: NB] = v[(ptr*W + j)*NB +: NB];
        end
        return c;
    endfunction

    task automatic model_reset();
        vq.delete();
        part   = '0;
        part_n = 0;
        ptr    = 0;
        ovf    = 0;
    endtask

    task automatic model_step(input bit we, input logic [NB-1:0] d, input bit rc, input bit rp, input bit rl);
        int sz = vq.size();
        bit done = 0;
        if (we) begin
            if (sz == 2) ovf = 1;
            else begin
                part[part_n*NB +: NB] = d;
                part_n++;
                done = (part_n == L);
            end
        end
        if (sz > 0) begin
            if (rl) begin
                void'(vq.pop_front());
                ptr = 0;
            end else if (rp) ptr = 0;
            else if (rc) ptr = (ptr + 1) % NC;
        end
        if (done) begin
            vq.push_back(part);
            part_n = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".data_ready"}, 32'(data_ready), 32'(vq.size() > 0));
        check({tag, ".wr_full"},    32'(wr_full),    32'(vq.size() == 2));
        check({tag, ".overflow"},   32'(overflow),   32'(ovf));
        check({tag, ".chunk"},      32'(chunk_data), 32'(exp_chunk()));
    endtask

    task automatic cycle(input bit we, input logic [NB-1:0] d, input bit rc, input bit rp, input bit rl,
                         input string tag);
        wr_en = we; wr_data = d; rd_chunk = rc; rd_ptr_rst = rp; rd_release = rl;
        @(posedge clk_in);
        model_step(we, d, rc, rp, rl);
        #1;
        compare_all(tag);
    endtask

    initial begin
        rst_in = 1'b0;
        wr_en = 0; wr_data = '0; rd_chunk = 0; rd_ptr_rst = 0; rd_release = 0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        compare_all("reset");
        @(negedge clk_in) rst_in = 1'b1;

        // Fill
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, 0, "fill");
        check("fill.first_chunk", 32'(chunk_data), 32'h0201);
        cycle(0, 0, 1, 0, 0, "rd1");
        check("fill.second_chunk", 32'(chunk_data), 32'h0403);
        cycle(0, 0, 1, 0, 0, "wrap");
        check("fill.wrap", 32'(chunk_data), 32'h0201);

        // Re-sweep and rewind priority
        cycle(0, 0, 1, 0, 0, "rs1");
        cycle(0, 0, 0, 1, 0, "rewind");
        check("resweep.rewind", 32'(chunk_data), 32'h0201);
        cycle(0, 0, 1, 0, 0, "rs2");
        cycle(0, 0, 1, 1, 0, "rewind_wins");
        check("resweep.rewind_wins", 32'(chunk_data), 32'h0201);

        // Ping-pong and overflow
        for (int i = 5; i <= 8; i++) cycle(1, 8'(i), 0, 0, 0, "pp_fill");
        check("pp.wr_full", 32'(wr_full), 32'd1);
        cycle(1, 8'd9, 0, 0, 0, "pp_drop");
        check("pp.overflow", 32'(overflow), 32'd1);
        cycle(0, 0, 0, 0, 0, "pp_sticky");
        check("pp.overflow_sticky", 32'(overflow), 32'd1);
        cycle(0, 0, 0, 0, 1, "pp_release");
        check("pp.release_chunk", 32'(chunk_data), 32'h0605);
        check("pp.release_not_full", 32'(wr_full), 32'd0);

        // Concurrent write completion and release
        cycle(1, 8'd10, 1, 0, 0, "cc");
        cycle(1, 8'd11, 1, 0, 0, "cc");
        cycle(1, 8'd12, 0, 0, 0, "cc");
        cycle(1, 8'd13, 0, 0, 1, "cc_last");
        check("cc.ready", 32'(data_ready), 32'd1);
        check("cc.chunk", 32'(chunk_data), 32'h0B0A);
        check("cc.not_full", 32'(wr_full), 32'd0);

        // Empty misuse
        cycle(0, 0, 0, 0, 1, "drain");
        check("empty.ready", 32'(data_ready), 32'd0);
        cycle(0, 0, 1, 0, 0, "empty_chunk");
        cycle(0, 0, 0, 1, 0, "empty_rst");
        cycle(0, 0, 0, 0, 1, "empty_rel");
        check("empty.chunk_zero", 32'(chunk_data), 32'd0);
        cycle(0, 0, 1, 0, 0, "empty_chunk2");
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i + 32), 0, 0, 0, "empty_refill");
        check("empty.ptr_stayed_zero", 32'(chunk_data), 32'h2221);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(99) < 50), 8'($urandom), ($urandom_range(99) < 40),
                  ($urandom_range(99) < 15), ($urandom_range(99) < 10), "rand");
        end

        // Async reset mid-vector with state still held from the random phase
        for (int i = 1; i <= 2; i++) cycle(1, 8'(i + 64), 0, 0, 0, "pre_rst");
        wr_en = 0; rd_chunk = 0; rd_ptr_rst = 0; rd_release = 0;
        #3;
        rst_in = 1'b0;
        #1;
        model_reset();
        check("arst.data_ready", 32'(data_ready), 32'd0);
        check("arst.wr_full",    32'(wr_full),    32'd0);
        check("arst.overflow",   32'(overflow),   32'd0);
        check("arst.chunk",      32'(chunk_data), 32'd0);
        @(negedge clk_in) rst_in = 1'b1;
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, 0, "post_rst");
        check("arst.refill_chunk", 32'(chunk_data), 32'h0201);
        check("arst.refill_ready", 32'(data_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
